// File: rtl/mips_mdu_pkg.sv
// Shared opcode and state encodings for the MIPS multiply/divide unit.
package mips_mdu_pkg;

    localparam int MDU_OP_W = 3;

    typedef enum logic [MDU_OP_W-1:0] {
        MDU_MULT  = 3'd0,
        MDU_MULTU = 3'd1,
        MDU_DIV   = 3'd2,
        MDU_DIVU  = 3'd3,
        MDU_MTHI  = 3'd4,
        MDU_MTLO  = 3'd5
    } mdu_op_e;

    typedef enum logic {
        MDU_IDLE = 1'b0,
        MDU_RUN  = 1'b1
    } mdu_state_e;

endpackage

// File: rtl/mips_mdu_latency_ctr.sv
// Down-counter modelling the fixed latency of a multiply or divide.
// o_done is high while the count sits at 1, i.e. on the cycle before the commit edge.
module mips_mdu_latency_ctr #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_clear,
    output logic             o_done
);

    logic [CNT_W-1:0] r_count;

    // NOTE: sequential state always uses non-blocking assignments so every
    // register samples its inputs from the same pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign o_done = (r_count == CNT_W'(1));

endmodule

// File: rtl/mips_mdu.sv
// Multi-cycle MULT/DIV unit with architectural HI/LO. Results are computed at
// start into shadow registers and committed after a fixed latency.
module mips_mdu
    import mips_mdu_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [MDU_OP_W-1:0] op,
    input  logic [WIDTH-1:0]    a,
    input  logic [WIDTH-1:0]    b,
    input  logic                flush,
    output logic                busy,
    output logic [WIDTH-1:0]    hi,
    output logic [WIDTH-1:0]    lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    mdu_state_e r_state;
    logic [WIDTH-1:0] r_sh_hi, r_sh_lo;
    logic             r_sh_valid;

    mdu_op_e                 w_op;
    logic                    w_is_muldiv, w_is_div, w_sh_valid, w_done;
    logic                    w_launch, w_abort, w_div_zero;
    logic [WIDTH-1:0]        w_sh_hi, w_sh_lo, w_ub_nz;
    logic signed [2*WIDTH-1:0] w_sa, w_sb, w_sb_nz, w_prod_s;
    logic [2*WIDTH-1:0]      w_ua, w_ub, w_prod_u;

    assign w_op       = mdu_op_e'(op);
    assign w_div_zero = (b == '0);

    assign w_sa     = {{WIDTH{a[WIDTH-1]}}, a};
    assign w_sb     = {{WIDTH{b[WIDTH-1]}}, b};
    assign w_ua     = {{WIDTH{1'b0}}, a};
    assign w_ub     = {{WIDTH{1'b0}}, b};
    assign w_prod_s = w_sa * w_sb;
    assign w_prod_u = w_ua * w_ub;

    // Divisor of zero is swapped for one so the dividers never see x/0; the
    // result is discarded at commit anyway. Dividing at double width makes
    // MIN_INT / -1 truncate to MIN_INT with a zero remainder on its own.
    assign w_sb_nz = w_div_zero ? {{(2*WIDTH-1){1'b0}}, 1'b1} : w_sb;
    assign w_ub_nz = w_div_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : b;

    always_comb begin
        w_sh_hi     = '0;
        w_sh_lo     = '0;
        w_sh_valid  = 1'b1;
        w_is_muldiv = 1'b1;
        w_is_div    = 1'b0;
        case (w_op)
            MDU_MULT:  {w_sh_hi, w_sh_lo} = w_prod_s;
            MDU_MULTU: {w_sh_hi, w_sh_lo} = w_prod_u;
            MDU_DIV: begin
                w_is_div   = 1'b1;
                w_sh_lo    = WIDTH'(w_sa / w_sb_nz);
                w_sh_hi    = WIDTH'(w_sa % w_sb_nz);
                w_sh_valid = ~w_div_zero;
            end
            MDU_DIVU: begin
                w_is_div   = 1'b1;
                w_sh_lo    = a / w_ub_nz;
                w_sh_hi    = a % w_ub_nz;
                w_sh_valid = ~w_div_zero;
            end
            default: w_is_muldiv = 1'b0;
        endcase
    end

    // Flush always beats a same-cycle start, so a flushed start never launches.
    assign w_launch = (r_state == MDU_IDLE) && start && !flush && w_is_muldiv;
    assign w_abort  = (r_state == MDU_RUN) && flush;

    mips_mdu_latency_ctr #(.CNT_W(CNT_W)) u_latency_ctr (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_launch),
        .i_load_val (w_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES)),
        .i_clear    (w_abort),
        .o_done     (w_done)
    );

    // NOTE: the shadow result registers are reset along with HI/LO so no
    // unknown value can ever reach the architectural state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= MDU_IDLE;
            busy       <= 1'b0;
            hi         <= '0;
            lo         <= '0;
            r_sh_hi    <= '0;
            r_sh_lo    <= '0;
            r_sh_valid <= 1'b0;
        end else begin
            case (r_state)
                MDU_IDLE: begin
                    if (start && !flush) begin
                        if (w_is_muldiv) begin
                            r_sh_hi    <= w_sh_hi;
                            r_sh_lo    <= w_sh_lo;
                            r_sh_valid <= w_sh_valid;
                            busy       <= 1'b1;
                            r_state    <= MDU_RUN;
                        end else if (w_op == MDU_MTHI) begin
                            hi <= a;
                        end else if (w_op == MDU_MTLO) begin
                            lo <= a;
                        end
                    end
                end
                MDU_RUN: begin
                    if (flush) begin
                        busy    <= 1'b0;
                        r_state <= MDU_IDLE;
                    end else if (w_done) begin
                        if (r_sh_valid) begin
                            hi <= r_sh_hi;
                            lo <= r_sh_lo;
                        end
                        busy    <= 1'b0;
                        r_state <= MDU_IDLE;
                    end
                end
                default: r_state <= MDU_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_mdu.sv
// Self-checking bench for mips_mdu: directed corner cases plus randomized ops
// checked against a longint reference model of the MIPS HI/LO semantics.
module tb_mips_mdu;

    localparam int W      = 32;
    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    logic         clk, reset, start, flush, busy;
    logic [2:0]   op;
    logic [W-1:0] a, b, hi, lo;

    int           pass_cnt, total_cnt;
    logic [W-1:0] m_hi, m_lo;

    mips_mdu #(.WIDTH(W), .MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .flush (flush),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: architectural effect of one completed op on HI/LO.
    task automatic model_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                            inout logic [W-1:0] mh, inout logic [W-1:0] ml);
        longint          sx, sy, p, q, r;
        longint unsigned ux, uy, up;
        sx = $signed(x);
        sy = $signed(y);
        ux = x;
        uy = y;
        case (o)
            OP_MULT: begin p = sx * sy; mh = p[63:32]; ml = p[31:0]; end
            OP_MULTU: begin up = ux * uy; mh = up[63:32]; ml = up[31:0]; end
            OP_DIV: begin
                if (y == 0) begin
                end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                    ml = 32'h8000_0000;
                    mh = 32'h0;
                end else begin
                    q = sx / sy;
                    r = sx - q * sy;
                    ml = q[31:0];
                    mh = r[31:0];
                end
            end
            OP_DIVU: if (y != 0) begin ml = x / y; mh = x % y; end
            OP_MTHI: mh = x;
            OP_MTLO: ml = x;
            default: ;
        endcase
    endtask

    function automatic int latency(input logic [2:0] o);
        return (o == OP_DIV || o == OP_DIVU) ? DIV_N : MULT_N;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        tick();
        start = 1'b0;
    endtask

    // Counts busy cycles after an issue; gives up after a bounded budget.
    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (busy === 1'b1 && cyc < 200) begin
            cyc++;
            tick();
        end
    endtask

    task automatic test_reset();
        #12;
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (hi !== '0) $display("FAIL reset_hi: got %h want 0", hi); else pass_cnt++;
        total_cnt++; if (lo !== '0) $display("FAIL reset_lo: got %h want 0", lo); else pass_cnt++;
        #3 reset = 1'b0;
        tick();
    endtask

    task automatic test_directed();
        logic [2:0]   ops [4] = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIV};
        logic [W-1:0] xs  [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'h8000_0000};
        logic [W-1:0] ys  [4] = '{32'd7, 32'd2, 32'd2, 32'hFFFF_FFFF};
        logic [W-1:0] ehi [4] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0};
        logic [W-1:0] elo [4] = '{32'hFFFF_FFEB, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h8000_0000};
        int cyc;
        for (int i = 0; i < 4; i++) begin
            issue(ops[i], xs[i], ys[i]);
            wait_idle(cyc);
            model_op(ops[i], xs[i], ys[i], m_hi, m_lo);
            total_cnt++; if (cyc != latency(ops[i])) $display("FAIL directed%0d_latency: got %0d want %0d", i, cyc, latency(ops[i])); else pass_cnt++;
            total_cnt++; if (hi !== ehi[i]) $display("FAIL directed%0d_hi: got %h want %h", i, hi, ehi[i]); else pass_cnt++;
            total_cnt++; if (lo !== elo[i]) $display("FAIL directed%0d_lo: got %h want %h", i, lo, elo[i]); else pass_cnt++;
        end
    endtask

    task automatic test_div_zero();
        int cyc;
        issue(OP_MTHI, 32'h11, 32'h0);
        issue(OP_MTLO, 32'h22, 32'h0);
        m_hi = 32'h11;
        m_lo = 32'h22;
        issue(OP_DIV, 32'd5, 32'd0);
        wait_idle(cyc);
        total_cnt++; if (cyc != DIV_N) $display("FAIL divzero_latency: got %0d want %0d", cyc, DIV_N); else pass_cnt++;
        total_cnt++; if (hi !== 32'h11) $display("FAIL divzero_hi: got %h want 11", hi); else pass_cnt++;
        total_cnt++; if (lo !== 32'h22) $display("FAIL divzero_lo: got %h want 22", lo); else pass_cnt++;
    endtask

    task automatic test_move();
        int cyc;
        logic [W-1:0] lo_before;
        issue(OP_MTHI, 32'h1234, 32'h0);
        m_hi = 32'h1234;
        total_cnt++; if (hi !== 32'h1234) $display("FAIL mthi_hi: got %h want 1234", hi); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL mthi_busy: got %b want 0", busy); else pass_cnt++;
        issue(OP_DIVU, 32'd50, 32'd3);
        tick();
        lo_before = lo;
        issue(OP_MTLO, 32'hDEAD_BEEF, 32'h0);
        total_cnt++; if (lo !== lo_before) $display("FAIL mtlo_busy_lo: got %h want %h", lo, lo_before); else pass_cnt++;
        total_cnt++; if (busy !== 1'b1) $display("FAIL mtlo_busy_busy: got %b want 1", busy); else pass_cnt++;
        wait_idle(cyc);
        model_op(OP_DIVU, 32'd50, 32'd3, m_hi, m_lo);
        total_cnt++; if (cyc != DIV_N - 2) $display("FAIL mtlo_busy_remaining: got %0d want %0d", cyc, DIV_N - 2); else pass_cnt++;
        total_cnt++; if (lo !== m_lo || hi !== m_hi) $display("FAIL mtlo_busy_result: got %h/%h want %h/%h", hi, lo, m_hi, m_lo); else pass_cnt++;
    endtask

    task automatic test_flush();
        issue(OP_DIVU, 32'd100, 32'd7);
        tick();
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        total_cnt++; if (busy !== 1'b0) $display("FAIL flush_mid_busy: got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (hi !== m_hi || lo !== m_lo) $display("FAIL flush_mid_hilo: got %h/%h want %h/%h", hi, lo, m_hi, m_lo); else pass_cnt++;
        tick();
        total_cnt++; if (busy !== 1'b0) $display("FAIL flush_mid_stays_idle: got %b want 0", busy); else pass_cnt++;

        issue(OP_DIVU, 32'd100, 32'd7);
        repeat (DIV_N - 1) tick();
        total_cnt++; if (busy !== 1'b1) $display("FAIL flush_commit_prebusy: got %b want 1", busy); else pass_cnt++;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        total_cnt++; if (busy !== 1'b0) $display("FAIL flush_commit_busy: got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (hi !== m_hi || lo !== m_lo) $display("FAIL flush_commit_hilo: got %h/%h want %h/%h", hi, lo, m_hi, m_lo); else pass_cnt++;

        flush = 1'b1;
        issue(OP_MULT, 32'd3, 32'd3);
        issue(OP_MTLO, 32'hABCD, 32'd0);
        flush = 1'b0;
        total_cnt++; if (busy !== 1'b0) $display("FAIL flush_start_busy: got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (hi !== m_hi || lo !== m_lo) $display("FAIL flush_start_hilo: got %h/%h want %h/%h", hi, lo, m_hi, m_lo); else pass_cnt++;
    endtask

    task automatic test_async_reset();
        int cyc;
        issue(OP_MULT, 32'd9, 32'd9);
        tick();
        #3 reset = 1'b1;
        #1;
        total_cnt++; if (busy !== 1'b0) $display("FAIL async_reset_busy: got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (hi !== '0 || lo !== '0) $display("FAIL async_reset_hilo: got %h/%h want 0/0", hi, lo); else pass_cnt++;
        #2 reset = 1'b0;
        m_hi = '0;
        m_lo = '0;
        tick();
        issue(OP_MULT, 32'd6, 32'd7);
        wait_idle(cyc);
        total_cnt++; if (cyc != MULT_N) $display("FAIL post_reset_latency: got %0d want %0d", cyc, MULT_N); else pass_cnt++;
        total_cnt++; if (lo !== 32'd42 || hi !== 32'd0) $display("FAIL post_reset_mult: got %h/%h want 0/2a", hi, lo); else pass_cnt++;
        m_lo = 32'd42;
    endtask

    task automatic test_back_to_back();
        int cyc;
        issue(OP_MULTU, 32'h0001_0000, 32'h0001_0000);
        wait_idle(cyc);
        model_op(OP_MULTU, 32'h0001_0000, 32'h0001_0000, m_hi, m_lo);
        issue(OP_MTHI, 32'h5555_AAAA, 32'd0);
        model_op(OP_MTHI, 32'h5555_AAAA, 32'd0, m_hi, m_lo);
        total_cnt++; if (hi !== m_hi || lo !== m_lo) $display("FAIL b2b_mthi: got %h/%h want %h/%h", hi, lo, m_hi, m_lo); else pass_cnt++;
        issue(OP_DIV, 32'hFFFF_FF9C, 32'd7);
        wait_idle(cyc);
        model_op(OP_DIV, 32'hFFFF_FF9C, 32'd7, m_hi, m_lo);
        total_cnt++; if (cyc != DIV_N) $display("FAIL b2b_div_latency: got %0d want %0d", cyc, DIV_N); else pass_cnt++;
        total_cnt++; if (hi !== m_hi || lo !== m_lo) $display("FAIL b2b_div: got %h/%h want %h/%h", hi, lo, m_hi, m_lo); else pass_cnt++;
    endtask

    task automatic test_random();
        int cyc;
        logic [2:0]   o;
        logic [W-1:0] x, y;
        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 5));
            x = $urandom;
            case ($urandom_range(0, 4))
                0: y = '0;
                1: y = W'($urandom_range(1, 9));
                2: y = -W'($urandom_range(1, 9));
                3: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
                default: y = $urandom;
            endcase
            issue(o, x, y);
            if (o >= OP_MTHI) begin
                model_op(o, x, y, m_hi, m_lo);
                total_cnt++; if (busy !== 1'b0) $display("FAIL rand%0d_move_busy: got %b want 0", i, busy); else pass_cnt++;
            end else begin
                wait_idle(cyc);
                model_op(o, x, y, m_hi, m_lo);
                total_cnt++; if (cyc != latency(o)) $display("FAIL rand%0d_latency op%0d: got %0d want %0d", i, o, cyc, latency(o)); else pass_cnt++;
            end
            total_cnt++;
            if (hi !== m_hi || lo !== m_lo)
                $display("FAIL rand%0d_result op%0d a=%h b=%h: got %h/%h want %h/%h", i, o, x, y, hi, lo, m_hi, m_lo);
            else pass_cnt++;
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        op = '0;
        a = '0;
        b = '0;
        pass_cnt = 0;
        total_cnt = 0;
        m_hi = '0;
        m_lo = '0;
        test_reset();
        test_directed();
        test_div_zero();
        test_move();
        test_flush();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
